// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared types and defaults for the parametrised register file.
//   - rf_state_t : bulk-clear sequencer states (RF_IDLE, RF_CLEAR)
//   - RF_DATA_W  : default register width
//   - RF_ADDR_W  : default address width (DEPTH = 2**ADDR_W)
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 16;
  localparam int unsigned RF_ADDR_W = 4;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq
//   Bulk-clear sequencer: on a request in IDLE, walks ptr from 0 to DEPTH-1,
//   zeroing one array entry per clock, then pulses clr_done.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   clr_req   in   request a clear (ignored while a clear is running)
//   clr_busy  out  registered, high while the sequence runs
//   clr_done  out  registered, one-cycle pulse after the last entry is cleared
//   clr_en    out  clear entry clr_addr at the next rising edge
//   clr_addr  out  entry to clear
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_t         state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic              done_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RF_IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      clr_busy <= (state_n == RF_CLEAR);
      clr_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    done_n  = 1'b0;
    case (state)
      RF_IDLE: begin
        if (clr_req) begin
          state_n = RF_CLEAR;
          ptr_n   = '0;
        end
      end
      RF_CLEAR: begin
        // Terminal detect on the last address; ptr is reloaded rather than
        // left to wrap.
        if (ptr == '1) begin
          state_n = RF_IDLE;
          ptr_n   = '0;
          done_n  = 1'b1;
        end else begin
          ptr_n = ptr + 1'b1;
        end
      end
      default: begin
        state_n = RF_IDLE;
        ptr_n   = '0;
      end
    endcase
  end

  assign clr_en   = (state == RF_CLEAR);
  assign clr_addr = ptr;

endmodule : regfile_clear_seq

// File: rtl/reg_file_param.sv
// reg_file_param
//   Parametrised register file: one write port, two combinational read ports,
//   a never-bypassed debug read port, optional hard-wired zero register and a
//   sequential bulk-clear engine.
//   Optional feature macro: REGFILE_BYPASS_EN (write-to-read bypass on rd1/rd2).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   we, wa, wd      write enable / address / data
//   ra1, ra2        read addresses;   rd1, rd2 combinational read data
//   dbg_a           debug address;    dbg_d combinational debug data
//   clr_req         bulk-clear request
//   clr_busy        clear in progress (registered)
//   clr_done        one-cycle completion pulse (registered)
//   wr_drop         write requested but discarded
module reg_file_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_a,
  output logic [DATA_W-1:0] dbg_d,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wa_zero;
  logic              wr_ok;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign wa_zero = ZERO_REG && (wa == '0);
  assign wr_ok   = we && !clr_busy && !wa_zero;
  assign wr_drop = we && (clr_busy || wa_zero);

  // clr_en implies clr_busy, so a clear and an accepted write never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = (ZERO_REG && (ra1 == '0)) ? '0 : mem[ra1];
    rd2 = (ZERO_REG && (ra2 == '0)) ? '0 : mem[ra2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (ra1 == wa)) rd1 = wd;
    if (wr_ok && (ra2 == wa)) rd2 = wd;
`endif
  end

  assign dbg_d = mem[dbg_a];

endmodule : reg_file_param
